// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, vector-op wait, branch flush.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_vec_op,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             vec_done,
    output logic             if_id_hold,
    output logic             pc_hold,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             vec_start,
    output logic [15:0]      stall_cnt
);

    typedef enum logic [1:0] {RUN, LOAD_STALL, VEC_WAIT, FLUSH} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic       load_use;
    logic       hold_c, flush_c, bubble_c, start_c;

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        hold_c      = 1'b0;
        flush_c     = 1'b0;
        bubble_c    = 1'b0;
        start_c     = 1'b0;
        if (ex_branch_taken) begin
            // A taken branch overrides everything, including an in-flight vector op.
            flush_c     = 1'b1;
            bubble_c    = 1'b1;
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_LOAD;
        end else begin
            case (state_q)
                RUN: begin
                    if (load_use) begin
                        hold_c   = 1'b1;
                        bubble_c = 1'b1;
                        state_d  = LOAD_STALL;
                    end else if (id_vec_op) begin
                        start_c = 1'b1;
                        state_d = VEC_WAIT;
                    end
                end
                LOAD_STALL: state_d = RUN;
                VEC_WAIT: begin
                    if (vec_done) begin
                        state_d = RUN;
                    end else begin
                        hold_c   = 1'b1;
                        bubble_c = 1'b1;
                    end
                end
                FLUSH: begin
                    // Branch cycle is the first flush pulse; this state supplies the rest.
                    if (flush_cnt_q != '0) begin
                        flush_c     = 1'b1;
                        flush_cnt_d = flush_cnt_q - 3'd1;
                        if (flush_cnt_q == 3'd1) state_d = RUN;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Outputs are forced low while reset is held, independent of inputs.
    assign if_id_hold   = rst_n & hold_c;
    assign pc_hold      = rst_n & hold_c;
    assign if_id_flush  = rst_n & flush_c;
    assign id_ex_bubble = rst_n & bubble_c;
    assign vec_start    = rst_n & start_c;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (if_id_hold && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2).
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_vec_op, ex_mem_read, ex_branch_taken, vec_done;
    logic        if_id_hold, pc_hold, if_id_flush, id_ex_bubble, vec_start;
    logic [15:0] stall_cnt;
    logic [4:0]  outs;

    int total = 0;
    int bad   = 0;

    // outs = {if_id_hold, pc_hold, if_id_flush, id_ex_bubble, vec_start}
    localparam logic [4:0] O_NONE  = 5'b00000;
    localparam logic [4:0] O_STALL = 5'b11010;
    localparam logic [4:0] O_FLUSH = 5'b00110;
    localparam logic [4:0] O_FONLY = 5'b00100;
    localparam logic [4:0] O_START = 5'b00001;

    assign outs = {if_id_hold, pc_hold, if_id_flush, id_ex_bubble, vec_start};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_vec_op(id_vec_op),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .vec_done(vec_done),
        .if_id_hold(if_id_hold), .pc_hold(pc_hold), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .vec_start(vec_start), .stall_cnt(stall_cnt)
    );

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic vop,
                         input logic mrd, input logic [4:0] rd, input logic br, input logic vd);
        id_rs1 = rs1; id_rs2 = rs2; id_vec_op = vop;
        ex_mem_read = mrd; ex_rd = rd; ex_branch_taken = br; vec_done = vd;
    endtask

    // Move to the next cycle's stimulus point, apply inputs, let comb logic settle.
    task automatic cyc(input logic [4:0] rs1, input logic [4:0] rs2, input logic vop,
                       input logic mrd, input logic [4:0] rd, input logic br, input logic vd);
        @(negedge clk);
        drive(rs1, rs2, vop, mrd, rd, br, vd);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        #3;
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs, O_NONE); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        @(negedge clk); @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL reset_release got=%b exp=%b", outs, O_NONE); end
    endtask

    task automatic test_load_use;
        cyc(5'd7, 5'd3, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
        total++; if (outs !== O_STALL) begin bad++; $display("FAIL lu_stall got=%b exp=%b", outs, O_STALL); end
        cyc(5'd7, 5'd3, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL lu_one_cycle got=%b exp=%b", outs, O_NONE); end
        total++; if (stall_cnt !== 16'(PERF * 1)) begin bad++; $display("FAIL lu_cnt1 got=%0d exp=%0d", stall_cnt, PERF); end
        cyc(5'd7, 5'd3, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
        total++; if (outs !== O_STALL) begin bad++; $display("FAIL lu_back_in_run got=%b exp=%b", outs, O_STALL); end
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL lu_idle got=%b exp=%b", outs, O_NONE); end
        total++; if (stall_cnt !== 16'(PERF * 2)) begin bad++; $display("FAIL lu_cnt2 got=%0d exp=%0d", stall_cnt, PERF * 2); end
    endtask

    task automatic test_no_hazard;
        cyc(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL x0_no_stall got=%b exp=%b", outs, O_NONE); end
        cyc(5'd9, 5'd1, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0);
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL not_load got=%b exp=%b", outs, O_NONE); end
        cyc(5'd9, 5'd1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL no_match got=%b exp=%b", outs, O_NONE); end
        cyc(5'd9, 5'd1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        total++; if (outs !== O_STALL) begin bad++; $display("FAIL rs1_match got=%b exp=%b", outs, O_STALL); end
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_vec;
        cyc(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        total++; if (outs !== O_START) begin bad++; $display("FAIL vec_start got=%b exp=%b", outs, O_START); end
        for (int i = 0; i < 4; i++) begin
            cyc(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
            total++; if (outs !== O_STALL) begin bad++; $display("FAIL vec_wait%0d got=%b exp=%b", i, outs, O_STALL); end
        end
        cyc(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL vec_done got=%b exp=%b", outs, O_NONE); end
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL vec_done_run got=%b exp=%b", outs, O_NONE); end
        total++; if (stall_cnt !== 16'(PERF * 7)) begin bad++; $display("FAIL vec_cnt got=%0d exp=%0d", stall_cnt, PERF * 7); end
    endtask

    task automatic test_branch_in_vec;
        cyc(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        total++; if (outs !== O_START) begin bad++; $display("FAIL bv_start got=%b exp=%b", outs, O_START); end
        cyc(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        total++; if (outs !== O_STALL) begin bad++; $display("FAIL bv_wait got=%b exp=%b", outs, O_STALL); end
        cyc(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        total++; if (outs !== O_FLUSH) begin bad++; $display("FAIL bv_branch got=%b exp=%b", outs, O_FLUSH); end
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++; if (outs !== O_FONLY) begin bad++; $display("FAIL bv_flush2 got=%b exp=%b", outs, O_FONLY); end
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL bv_late_done got=%b exp=%b", outs, O_NONE); end
        cyc(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
        total++; if (outs !== O_STALL) begin bad++; $display("FAIL bv_run_after got=%b exp=%b", outs, O_STALL); end
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++; if (stall_cnt !== 16'(PERF * 9)) begin bad++; $display("FAIL bv_cnt got=%0d exp=%0d", stall_cnt, PERF * 9); end
    endtask

    task automatic test_branch_priority;
        cyc(5'd3, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        total++; if (outs !== O_FLUSH) begin bad++; $display("FAIL prio_branch got=%b exp=%b", outs, O_FLUSH); end
        cyc(5'd3, 5'd0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        total++; if (outs !== O_FONLY) begin bad++; $display("FAIL prio_flush2 got=%b exp=%b", outs, O_FONLY); end
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL prio_no_lstall got=%b exp=%b", outs, O_NONE); end
        total++; if (stall_cnt !== 16'(PERF * 9)) begin bad++; $display("FAIL prio_cnt got=%0d exp=%0d", stall_cnt, PERF * 9); end
    endtask

    task automatic test_back_to_back;
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        total++; if (outs !== O_FLUSH) begin bad++; $display("FAIL bb_br1 got=%b exp=%b", outs, O_FLUSH); end
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        total++; if (outs !== O_FLUSH) begin bad++; $display("FAIL bb_br2 got=%b exp=%b", outs, O_FLUSH); end
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++; if (outs !== O_FONLY) begin bad++; $display("FAIL bb_reload got=%b exp=%b", outs, O_FONLY); end
        cyc(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        total++; if (outs !== O_START) begin bad++; $display("FAIL bb_run_after got=%b exp=%b", outs, O_START); end
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL bb_done got=%b exp=%b", outs, O_NONE); end
    endtask

    task automatic test_reset_mid_seq;
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++; if (outs !== O_FONLY) begin bad++; $display("FAIL rf_flush got=%b exp=%b", outs, O_FONLY); end
        rst_n = 1'b0;
        #1;
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL rf_async got=%b exp=%b", outs, O_NONE); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rf_cnt got=%0d exp=0", stall_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL rf_release got=%b exp=%b", outs, O_NONE); end
        cyc(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        total++; if (outs !== O_START) begin bad++; $display("FAIL rf_run got=%b exp=%b", outs, O_START); end
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++; if (outs !== O_STALL) begin bad++; $display("FAIL rv_wait got=%b exp=%b", outs, O_STALL); end
        rst_n = 1'b0;
        #1;
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL rv_async got=%b exp=%b", outs, O_NONE); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++; if (outs !== O_NONE) begin bad++; $display("FAIL rv_aborted got=%b exp=%b", outs, O_NONE); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rv_cnt got=%0d exp=0", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_vec();
        test_branch_in_vec();
        test_branch_priority();
        test_back_to_back();
        test_reset_mid_seq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
